// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_arb_pkg
// Brief    : Shared types and defaults for the multiplier arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int W_DEF    = 16;
    localparam int RW_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Round-robin pointer width; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set req bit at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any_valid
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;

    always_comb begin
        gnt       = '0;
        any_valid = 1'b0;
        w_sum     = '0;
        w_idx     = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_sum = {1'b0, ptr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!any_valid && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                any_valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Round-robin scheduler sharing one sequential multiplier among
//            NREQ requesters, with zero-operand bypass.
//            Optional watchdog: define MULT_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int W           = W_DEF,
    parameter int RW          = RW_DEF,
    parameter int TIMEOUT_CYC = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [RW-1:0]     rsp_data,
    output logic              err,
    output logic              mul_start,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic              mul_done,
    input  logic [RW-1:0]     mul_res
);

    localparam int PW = ptr_width(NREQ);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_pick;
    logic            w_any;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic            w_zero_op;
    logic            w_timeout;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req       (req),
        .ptr       (r_ptr),
        .gnt       (w_pick),
        .any_valid (w_any)
    );

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_sel_a = a_in[i*W +: W];
                w_sel_b = b_in[i*W +: W];
            end
        end
    end

    // The multiplier's normalise loop never ends on zero, so zero never goes there.
    assign w_zero_op = (w_sel_a == '0) || (w_sel_b == '0);

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                w_gidx = PW'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == PW'(NREQ-1)) ? '0 : w_gidx + PW'(1);

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC+1) > 8) ? $clog2(TIMEOUT_CYC+1) : 8;

    logic [TW-1:0] r_tcnt;
    logic          r_err;

    // Fires on the last allowed WAIT cycle; a coincident mul_done wins.
    assign w_timeout = (r_state == WAIT) && !mul_done &&
                       (r_tcnt == TW'(TIMEOUT_CYC-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == ISSUE) begin
                r_tcnt <= '0;
            end else if (r_state == WAIT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_nxt = ARB;
            ARB: begin
                if (!w_any) begin
                    w_state_nxt = IDLE;
                end else if (w_zero_op) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE:   w_state_nxt = WAIT;
            WAIT:    if (mul_done || w_timeout) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered on the transition so each is high while in its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
        end else begin
            mul_start <= (w_state_nxt == ISSUE);
            rsp_valid <= '0;
            case (r_state)
                ARB: begin
                    gnt   <= w_pick;
                    mul_a <= w_sel_a;
                    mul_b <= w_sel_b;
                    if (w_any && w_zero_op) begin
                        rsp_data  <= '0;
                        rsp_valid <= w_pick;
                    end
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_data  <= mul_res;
                        rsp_valid <= gnt;
                    end else if (w_timeout) begin
                        rsp_data  <= '0;
                        rsp_valid <= gnt;
                    end
                end
                RESP: begin
                    gnt   <= '0;
                    r_ptr <= w_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Scoreboard bench for mult_arbiter with a behavioural multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int NREQ        = 4;
    localparam int W           = 16;
    localparam int RW          = 32;
    localparam int TIMEOUT_CYC = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic              err;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [RW-1:0]     mul_res;

    typedef struct {
        int            idx;
        logic [RW-1:0] data;
        bit            err;
        bit            via_mul;
        int            exp_cyc;
    } exp_t;

    exp_t sb[$];

    int n_checks    = 0;
    int n_pass      = 0;
    int cyc         = 0;
    int n_start     = 0;
    int start_cyc   = 0;
    int last_rsp_cyc = 0;
    bit start_prev  = 1'b0;
    int mdelay      = 5;
    bit model_en    = 1'b1;
    int mcnt        = 0;

    mult_arbiter #(
        .NREQ        (NREQ),
        .W           (W),
        .RW          (RW),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .err       (err),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_res   (mul_res)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response monitor and multiplier model share one process so their order is fixed.
    initial begin
        exp_t e;
        mul_done = 1'b0;
        mul_res  = '0;
        forever begin
            @(negedge clk);
            if (mul_start) begin
                check("start_single", 64'(start_prev), 64'd0);
                n_start++;
                start_cyc = cyc;
            end
            start_prev = mul_start;
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_onehot", 64'(rsp_valid), 64'(1) << e.idx);
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(err), 64'(e.err));
                    check("gnt_in_resp", 64'(gnt), 64'(1) << e.idx);
                    if (e.via_mul) check("done_to_rsp", 64'(mul_done), 64'd1);
                    if (e.exp_cyc >= 0) check("rsp_latency", 64'(cyc), 64'(e.exp_cyc));
                end
                last_rsp_cyc = cyc;
                req = req & ~rsp_valid;
            end
            mul_done = 1'b0;
            if (mul_start) begin
                mcnt    = model_en ? mdelay : 0;
                mul_res = RW'(mul_a) * RW'(mul_b);
            end else if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) mul_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic push(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_cyc);
        exp_t e;
        e.idx     = i;
        e.via_mul = (a != '0) && (b != '0);
        e.data    = e.via_mul ? RW'(a) * RW'(b) : '0;
        e.err     = 1'b0;
        e.exp_cyc = exp_cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || req != '0) && k < budget) begin
            tick();
            k++;
        end
        check("drain", 64'(sb.size()), 64'd0);
        ticks(2);
    endtask

    task automatic wait_start(input int budget);
        int s0 = n_start;
        int k  = 0;
        while (n_start == s0 && k < budget) begin
            tick();
            k++;
        end
        check("start_seen", 64'(n_start - s0), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int s0;
        req  = '0;
        a_in = '0;
        b_in = '0;
        rst  = 1'b0;
        ticks(3);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        rst = 1'b1;
        ticks(2);

        // Single request through the multiplier, grant held throughout.
        mdelay = 20;
        s0 = n_start;
        set_ops(0, 16'd3, 16'd5);
        push(0, 16'd3, 16'd5, -1);
        req[0] = 1'b1;
        tick();
        check("arb_gnt", 64'(gnt), 64'd0);
        check("arb_start", 64'(mul_start), 64'd0);
        tick();
        check("issue_gnt", 64'(gnt), 64'b0001);
        check("issue_start", 64'(mul_start), 64'd1);
        check("issue_mul_a", 64'(mul_a), 64'd3);
        check("issue_mul_b", 64'(mul_b), 64'd5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_gnt", 64'(gnt), 64'b0001);
        end
        drain(60);
        check("single_starts", 64'(n_start - s0), 64'd1);

        // Zero bypass: response two edges after the request is seen in IDLE.
        s0 = n_start;
        set_ops(2, 16'd0, 16'h1234);
        push(2, 16'd0, 16'h1234, cyc + 2);
        req[2] = 1'b1;
        drain(20);
        check("bypass_nostart", 64'(n_start - s0), 64'd0);

        // Drop after grant: response still delivered, pointer wraps to 0.
        mdelay = 8;
        set_ops(3, 16'd7, 16'd9);
        push(3, 16'd7, 16'd9, -1);
        req[3] = 1'b1;
        wait_start(10);
        ticks(2);
        req[3] = 1'b0;
        drain(40);

        // Round robin 0,1,2,3 then 0 again after it re-asserts.
        mdelay = 4;
        for (int i = 0; i < NREQ; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(1, 65535));
            rb = W'($urandom_range(1, 65535));
            set_ops(i, ra, rb);
            push(i, ra, rb, -1);
        end
        req = 4'b1111;
        begin
            int k = 0;
            while (req[0] && k < 50) begin
                tick();
                k++;
            end
            check("rr_first_rsp", 64'(req[0]), 64'd0);
        end
        tick();
        set_ops(0, 16'hFFFF, 16'hFFFF);
        push(0, 16'hFFFF, 16'hFFFF, -1);
        req[0] = 1'b1;
        drain(300);

        // Async reset in WAIT; the abandoned operation's late done must be ignored.
        mdelay = 30;
        set_ops(1, 16'd11, 16'd13);
        push(1, 16'd11, 16'd13, -1);
        req[1] = 1'b1;
        wait_start(10);
        ticks(5);
        rst = 1'b0;
        #1;
        check("arst_gnt", 64'(gnt), 64'd0);
        check("arst_mul_a", 64'(mul_a), 64'd0);
        check("arst_mul_b", 64'(mul_b), 64'd0);
        check("arst_mul_start", 64'(mul_start), 64'd0);
        check("arst_rsp_data", 64'(rsp_data), 64'd0);
        sb.delete();
        req = '0;
        ticks(2);
        rst = 1'b1;
        s0 = n_start;
        ticks(40);
        check("late_done_gnt", 64'(gnt), 64'd0);
        check("late_done_nostart", 64'(n_start - s0), 64'd0);
        mdelay = 10;
        push(1, 16'd11, 16'd13, -1);
        req[1] = 1'b1;
        drain(60);

        // Multiplier never answers.
        model_en = 1'b0;
        set_ops(2, 16'd100, 16'd200);
`ifdef MULT_ARB_TIMEOUT_EN
        begin
            exp_t e;
            e.idx     = 2;
            e.data    = '0;
            e.err     = 1'b1;
            e.via_mul = 1'b0;
            e.exp_cyc = -1;
            sb.push_back(e);
        end
        req[2] = 1'b1;
        drain(TIMEOUT_CYC + 50);
        check("timeout_latency", 64'(last_rsp_cyc - start_cyc), 64'(TIMEOUT_CYC + 1));
`else
        req[2] = 1'b1;
        ticks(TIMEOUT_CYC + 80);
        check("wait_holds_gnt", 64'(gnt), 64'b0100);
        check("wait_holds_mul_a", 64'(mul_a), 64'd100);
        check("wait_holds_mul_b", 64'(mul_b), 64'd200);
        req = '0;
        rst = 1'b0;
        ticks(2);
        rst = 1'b1;
        ticks(2);
        check("recover_gnt", 64'(gnt), 64'd0);
`endif
        model_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Scheduler that shares the single sequential approximate multiplier (16-bit operands, shift-normalise/multiply/shift-back controller) among NREQ requesters. It performs round-robin arbitration over level requests, drives the operands and a one-cycle start pulse, waits for the multiplier's done pulse, and returns the product to the granted requester with a one-cycle response strobe. Zero operands bypass the multiplier, because its normalisation loop never terminates on a zero operand. The block sits between the client units and the multiplier top level.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 16, operand width
- RW, 32, result width
- TIMEOUT_CYC, 128, watchdog limit in WAIT cycles (used only with MULT_ARB_TIMEOUT_EN)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester level request, held until its rsp_valid
- a_in  in  NREQ*W  packed operand A, slice i belongs to requester i
- b_in  in  NREQ*W  packed operand B
- gnt  out  NREQ  one-hot current grant, all-zero when idle
- rsp_valid  out  NREQ  one-cycle response strobe to the granted requester
- rsp_data  out  RW  registered product, shared by all requesters, valid with rsp_valid
- err  out  1  one-cycle strobe with rsp_valid on watchdog abort
- mul_start  out  1  start pulse to the multiplier
- mul_a, mul_b  out  W  registered operands to the multiplier
- mul_done  in  1  multiplier done pulse
- mul_res  in  RW  multiplier product, sampled when mul_done=1

## Operation
- States: IDLE, ARB, ISSUE, WAIT, RESP.
- IDLE: when any req bit is set, go to ARB. Otherwise stay.
- ARB: pick the first set req bit at or after the round-robin pointer ptr, wrapping modulo NREQ.
  - Register that bit into gnt and latch its operand slices into mul_a and mul_b.
  - If the latched a or b is zero, load rsp_data=0 and go to RESP (bypass path).
  - Otherwise go to ISSUE.
  - If req has dropped to all-zero by this cycle, return to IDLE with gnt=0.
- ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
- WAIT: mul_a and mul_b stay stable. When mul_done=1, capture mul_res into rsp_data and go to RESP.
- RESP: rsp_valid[g]=1 for one cycle, and ptr becomes (g+1) mod NREQ. Next state is IDLE with gnt cleared.
- A requester that drops req after its grant still gets its response. The operation is never cancelled.
- mul_done outside WAIT is ignored.
- A new req arriving during an operation waits. At most one operation is in flight.
- Reset (any state, asynchronous): state=IDLE, ptr=0, and gnt, rsp_valid, err, mul_start, mul_a, mul_b, rsp_data all 0.
  - A multiplier operation in flight at reset is abandoned; its later mul_done is ignored.

## Timing
- All outputs are registered.
- Bypass latency: req high to rsp_valid takes 3 cycles (IDLE→ARB→RESP).
- Multiplier latency: rsp_valid comes 1 cycle after the mul_done cycle. mul_start comes 2 cycles after req is seen in IDLE.
- mul_start is never high on two consecutive cycles. It is low for at least 3 cycles between issues, which satisfies the multiplier's wait-for-start-low rule.
- The requester must deassert req in the cycle after rsp_valid. If it is still high in IDLE, it is re-arbitrated as a new request.
- Back-to-back: the next ARB can follow RESP 2 cycles later (RESP→IDLE→ARB).

## Configuration
- MULT_ARB_TIMEOUT_EN defined: an 8-bit-plus counter runs in WAIT.
  - It clears on ISSUE.
  - On reaching TIMEOUT_CYC without mul_done: rsp_data=0, err=1 with rsp_valid, go to RESP, ptr advances as normal.
- MULT_ARB_TIMEOUT_EN undefined: no counter, WAIT holds indefinitely, err is tied 0.

## Structure
- mult_arb_pkg contains the state enum (IDLE, ARB, ISSUE, WAIT, RESP), default W, RW and NREQ constants, and a clog2-based pointer width.
- One sub-module: rr_pick (combinational). Inputs are req and ptr; outputs are a one-hot grant and an any-valid flag. It is instantiated once in ARB.

## Test plan
- Single request: req[0]=1, a=3, b=5, model done 20 cycles after start → mul_start single pulse, rsp_valid[0] with rsp_data=model product, gnt=0001 throughout.
- Round robin: req=1111 held, each requester re-asserts after its response → grants in order 0,1,2,3,0. ptr wraps from 3 to 0.
- Zero bypass: req[2]=1, a=0, b=0x1234 → no mul_start, rsp_valid[2] 3 cycles after req with rsp_data=0.
- Async reset asserted mid-WAIT, then released, then a late mul_done pulse → all outputs 0 immediately, late done ignored, next req[1] served normally.
- Timeout (macro on, TIMEOUT_CYC=128, mul_done never arrives) → rsp_valid and err on the same cycle 128 WAIT cycles after ISSUE, rsp_data=0. With the macro off, the FSM stays in WAIT.
- Drop-after-grant: req[3] released during WAIT → operation completes, rsp_valid[3] still pulses, ptr becomes 0.
